// File: rtl/fir_pair_serializer.sv
// Pair-to-stream serializer: buffers (y0, y1) result pairs in a small FIFO and
// emits them y0-then-y1 at one sample per handshake. Define FIR_SER_SAT_EN to saturate instead of truncate.
module fir_pair_serializer #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pair_valid,
  output logic                      pair_ready,
  input  logic signed [IN_W-1:0]    y0_in,
  input  logic signed [IN_W-1:0]    y1_in,
  output logic                      s_valid,
  input  logic                      s_ready,
  output logic signed [OUT_W-1:0]   s_data,
  output logic                      s_odd,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic                phase_r;
  logic [2*IN_W-1:0]   mem_r [DEPTH];

  logic                empty_s;
  logic                full_s;
  logic                push_s;
  logic                pop_s;
  logic [2*IN_W-1:0]   head_s;
  logic [IN_W-1:0]     sel_s;
  logic [OUT_W-1:0]    narrow_s;

`ifdef FIR_SER_SAT_EN
  // A value fits when every bit from the sign down to bit OUT_W-1 agrees.
  function automatic logic out_of_range(input logic [IN_W-1:0] v);
    logic [IN_W-OUT_W:0] top;
    top = v[IN_W-1:OUT_W-1];
    if ((top == {(IN_W-OUT_W+1){1'b0}}) || (top == {(IN_W-OUT_W+1){1'b1}})) begin
      out_of_range = 1'b0;
    end else begin
      out_of_range = 1'b1;
    end
  endfunction

  function automatic logic [OUT_W-1:0] narrow(input logic [IN_W-1:0] v);
    if (!out_of_range(v)) begin
      narrow = v[OUT_W-1:0];
    end else if (v[IN_W-1]) begin
      narrow = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      narrow = {1'b0, {(OUT_W-1){1'b1}}};
    end
  endfunction
`else
  logic unused_sel_s;
  assign unused_sel_s = ^sel_s;

  function automatic logic [OUT_W-1:0] narrow(input logic [OUT_W-1:0] v);
    narrow = v;
  endfunction
`endif

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign push_s  = pair_valid && !full_s;
  assign pop_s   = !empty_s && s_ready;
  assign head_s  = mem_r[rd_ptr_r[AW-1:0]];
  assign sel_s   = phase_r ? head_s[2*IN_W-1:IN_W] : head_s[IN_W-1:0];

`ifdef FIR_SER_SAT_EN
  assign narrow_s = narrow(sel_s);
`else
  assign narrow_s = narrow(sel_s[OUT_W-1:0]);
`endif

  // Pair storage; contents are don't-care after reset so no reset term.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {y1_in, y0_in};
    end
  end

  // Pointers and half-pair phase; rd_ptr only moves once y1 has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      phase_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        phase_r <= ~phase_r;
        if (phase_r) begin
          rd_ptr_r <= rd_ptr_r + PW'(1);
        end
      end
    end
  end

`ifdef FIR_SER_SAT_EN
  logic ovf_r;

  // Sticky flag raised when a clamped sample leaves the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (pop_s && out_of_range(sel_s)) begin
      ovf_r <= 1'b1;
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

  // Stream-side view derived purely from registered FIFO state.
  always_comb begin
    pair_ready = ~full_s;
    s_valid    = ~empty_s;
    s_odd      = phase_r;
    level      = wr_ptr_r - rd_ptr_r;
    if (empty_s) begin
      s_data = {OUT_W{1'b0}};
    end else begin
      s_data = narrow_s;
    end
  end

endmodule

// File: tb/tb_fir_pair_serializer.sv
// Randomized and directed bench for fir_pair_serializer against a sample-queue
// reference model (pending samples in order; level = pairs touched by them).
module tb_fir_pair_serializer;
  localparam int IN_W  = 64;
  localparam int OUT_W = 32;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    pair_valid;
  logic                    pair_ready;
  logic signed [IN_W-1:0]  y0_in;
  logic signed [IN_W-1:0]  y1_in;
  logic                    s_valid;
  logic                    s_ready;
  logic signed [OUT_W-1:0] s_data;
  logic                    s_odd;
  logic [LW-1:0]           level;
  logic                    ovf;

  longint q[$];
  logic [OUT_W-1:0] obs_pop[$];
  bit     ovf_m;
  int     checks = 0;
  int     failures = 0;

  always #5 clk = ~clk;

  fir_pair_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pair_valid(pair_valid), .pair_ready(pair_ready),
    .y0_in(y0_in), .y1_in(y1_in), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_odd(s_odd), .level(level), .ovf(ovf)
  );

  function automatic bit model_oor(longint v);
    return (v > 64'sd2147483647) || (v < -64'sd2147483648);
  endfunction

  function automatic logic [OUT_W-1:0] model_narrow(longint v);
`ifdef FIR_SER_SAT_EN
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
`endif
    return 32'(v);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, then advance the model past the edge.
  task automatic step(bit pv, longint a, longint b, bit sr);
    int  lvl;
    bit  do_push, do_pop;
    longint v;
    pair_valid = pv;
    y0_in = a;
    y1_in = b;
    s_ready = sr;
    #1;
    lvl = (q.size() + 1) / 2;
    chk("s_valid", 64'(s_valid), 64'(q.size() != 0));
    chk("s_data", 64'($unsigned(s_data)), 64'((q.size() != 0) ? model_narrow(q[0]) : 32'h0));
    chk("s_odd", 64'(s_odd), 64'(q.size() % 2));
    chk("level", 64'(level), 64'(lvl));
    chk("pair_ready", 64'(pair_ready), 64'(lvl < DEPTH));
    chk("ovf", 64'(ovf), 64'(ovf_m));
    do_push = pv && (lvl < DEPTH);
    do_pop  = sr && (q.size() != 0);
    if (do_pop) obs_pop.push_back($unsigned(s_data));
    @(posedge clk);
    if (do_pop) begin
      v = q.pop_front();
`ifdef FIR_SER_SAT_EN
      if (model_oor(v)) ovf_m = 1'b1;
`endif
    end
    if (do_push) begin
      q.push_back(a);
      q.push_back(b);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH + 4; i++) begin
      if (q.size() == 0) break;
      step(1'b0, 0, 0, 1'b1);
    end
    chk("drain_done", 64'(q.size()), 64'd0);
  endtask

  function automatic longint rnd_val();
    if ($urandom_range(0, 1) == 0) return longint'($signed(32'($urandom))) >>> $urandom_range(0, 20);
    return longint'({$urandom, $urandom});
  endfunction

  initial begin
    logic [OUT_W-1:0] exp_fill [8];
    exp_fill = '{32'd0, 32'd1, 32'd10, 32'd11, 32'd20, 32'd21, 32'd30, 32'd31};
    rst_n = 1'b0; pair_valid = 1'b0; s_ready = 1'b0; y0_in = '0; y1_in = '0;
    ovf_m = 1'b0;
    #1;
    chk("rst_s_valid", 64'(s_valid), 64'd0);
    chk("rst_pair_ready", 64'(pair_ready), 64'd1);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_s_data", 64'($unsigned(s_data)), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single pair 5 / -3 with downstream ready.
    obs_pop.delete();
    step(1'b1, 5, -3, 1'b1);
    repeat (3) step(1'b0, 0, 0, 1'b1);
    chk("pair1_count", 64'(obs_pop.size()), 64'd2);
    if (obs_pop.size() == 2) begin
      chk("pair1_y0", 64'(obs_pop[0]), 64'd5);
      chk("pair1_y1", 64'(obs_pop[1]), 64'h0000_0000_FFFF_FFFD);
    end
    chk("pair1_level0", 64'(level), 64'd0);

    // Fill while blocked, try a fifth pair, then release.
    for (int k = 0; k < 4; k++) step(1'b1, 10 * k, 10 * k + 1, 1'b0);
    chk("fill_level", 64'(level), 64'd4);
    chk("fill_ready", 64'(pair_ready), 64'd0);
    repeat (2) step(1'b1, 40, 41, 1'b0);
    chk("fill_no_5th", 64'(q.size()), 64'd8);
    obs_pop.delete();
    repeat (12) step(1'b1, 40, 41, 1'b1);
    for (int i = 0; i < 8; i++) chk("fill_order", 64'(obs_pop[i]), 64'(exp_fill[i]));
    drain();

    // Continuous pairs with ready high: pointers wrap several times.
    repeat (40) step(1'b1, rnd_val(), rnd_val(), 1'b1);
    drain();

    // Random backpressure on both sides.
    repeat (150) step($urandom_range(0, 1) == 1, rnd_val(), rnd_val(), $urandom_range(0, 2) != 0);
    drain();

    // Stall on the y1 half of a pair.
    step(1'b1, 3, 7, 1'b0);
    step(1'b0, 0, 0, 1'b1);
    repeat (3) step(1'b0, 0, 0, 1'b0);
    chk("stall_data", 64'($unsigned(s_data)), 64'd7);
    chk("stall_odd", 64'(s_odd), 64'd1);
    chk("stall_level", 64'(level), 64'd1);
    drain();

    // Asynchronous reset after only y0 has left.
    step(1'b1, 11, 12, 1'b0);
    step(1'b0, 0, 0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_s_valid", 64'(s_valid), 64'd0);
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_phase", 64'(s_odd), 64'd0);
    q.delete();
    ovf_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    obs_pop.delete();
    step(1'b1, 21, 22, 1'b1);
    repeat (2) step(1'b0, 0, 0, 1'b1);
    chk("arst_first_y0", 64'(obs_pop[0]), 64'd21);

    // Out-of-range pair.
    obs_pop.delete();
    step(1'b1, 64'sd1 <<< 40, -(64'sd1 <<< 40), 1'b1);
    repeat (3) step(1'b0, 0, 0, 1'b1);
`ifdef FIR_SER_SAT_EN
    chk("big_y0", 64'(obs_pop[0]), 64'h7FFF_FFFF);
    chk("big_y1", 64'(obs_pop[1]), 64'h8000_0000);
    chk("big_ovf", 64'(ovf), 64'd1);
`else
    chk("big_y0", 64'(obs_pop[0]), 64'd0);
    chk("big_y1", 64'(obs_pop[1]), 64'd0);
    chk("big_ovf", 64'(ovf), 64'd0);
`endif
    repeat (2) step(1'b0, 0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
